// File: rtl/smart_home_pkg.sv
// Shared smart-home definitions: alarm state encoding and down-counter terminal values.
package smart_home_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ENTRY    = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    localparam logic [1:0] CNT_TOP = 2'd3;
    localparam logic [1:0] CNT_BOT = 2'd0;

endpackage

// File: rtl/alarm_siren_gen.sv
// Siren square-wave generator: starts high when enabled, toggles every SIREN_HALF cycles.
module alarm_siren_gen #(
    parameter int unsigned SIREN_HALF = 4
) (
    input  logic CLK_IN,
    input  logic CLR_FF,
    input  logic EN,
    output logic SIREN
);

    localparam logic [7:0] HALF_LAST = 8'(SIREN_HALF - 1);

    logic [7:0] timer_q;
    logic       run_q;

    always_ff @(posedge CLK_IN or posedge CLR_FF) begin
        if (CLR_FF) begin
            timer_q <= '0;
            run_q   <= 1'b0;
            SIREN   <= 1'b0;
        end else if (!EN) begin
            timer_q <= '0;
            run_q   <= 1'b0;
            SIREN   <= 1'b0;
        end else if (!run_q) begin
            // first enabled cycle: siren goes high with the timer at zero
            timer_q <= '0;
            run_q   <= 1'b1;
            SIREN   <= 1'b1;
        end else if (timer_q == HALF_LAST) begin
            timer_q <= '0;
            SIREN   <= ~SIREN;
        end else begin
            timer_q <= timer_q + 8'd1;
        end
    end

endmodule

// File: rtl/smart_alarm_ctrl.sv
// Intrusion-alarm controller using the 2-bit down counter as entry-delay timebase.
module smart_alarm_ctrl
    import smart_home_pkg::*;
#(
    parameter int unsigned ENTRY_PERIODS = 2,
    parameter int unsigned SIREN_HALF    = 4
) (
    input  logic       CLK_IN,
    input  logic       CLR_FF,
    input  logic [1:0] CNT_IN,
    input  logic       ARM,
    input  logic       DISARM,
    input  logic       DOOR,
    output logic       CNT_CLR,
    output logic [1:0] STATE,
    output logic       SIREN,
    output logic       ENTRY_LED,
    output logic [1:0] DISP
);

    localparam logic [3:0] LAST_PERIOD = 4'(ENTRY_PERIODS - 1);

    state_t     state_q;
    state_t     state_nxt;
    logic [3:0] period_q;
    logic [1:0] prev_q;
    logic       wrap;

    assign wrap  = (prev_q == CNT_BOT) && (CNT_IN == CNT_TOP);
    assign STATE = state_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_DISARMED: if (ARM && !DISARM) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (DISARM)    state_nxt = ST_DISARMED;
                else if (DOOR) state_nxt = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (DISARM)                             state_nxt = ST_DISARMED;
                else if (wrap && period_q == LAST_PERIOD) state_nxt = ST_ALARM;
            end
            ST_ALARM: if (DISARM) state_nxt = ST_DISARMED;
            default:  state_nxt = ST_DISARMED;
        endcase
    end

    always_ff @(posedge CLK_IN or posedge CLR_FF) begin
        if (CLR_FF) begin
            state_q   <= ST_DISARMED;
            CNT_CLR   <= 1'b1;
            ENTRY_LED <= 1'b0;
            DISP      <= '0;
            period_q  <= '0;
            prev_q    <= CNT_TOP;
        end else begin
            state_q   <= state_nxt;
            CNT_CLR   <= (state_nxt != ST_ENTRY);
            ENTRY_LED <= (state_nxt == ST_ENTRY);
            DISP      <= (state_nxt == ST_ENTRY) ? CNT_IN : '0;
            // outside ENTRY the history is parked at the top so re-entry never sees a stale 0
            prev_q    <= (state_q == ST_ENTRY) ? CNT_IN : CNT_TOP;
            if (state_q == ST_ARMED && state_nxt == ST_ENTRY)
                period_q <= '0;
            else if (state_q == ST_ENTRY && wrap)
                period_q <= period_q + 4'd1;
        end
    end

    alarm_siren_gen #(
        .SIREN_HALF(SIREN_HALF)
    ) u_siren (
        .CLK_IN(CLK_IN),
        .CLR_FF(CLR_FF),
        .EN    (state_nxt == ST_ALARM),
        .SIREN (SIREN)
    );

endmodule

// File: tb/tb_smart_alarm_ctrl.sv
// Scoreboard bench for smart_alarm_ctrl: directed vectors push expectations, a monitor compares.
module tb_smart_alarm_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic       clr;
        logic       siren;
        logic       led;
        logic [1:0] disp;
    } obs_t;

    logic       clk = 1'b0;
    logic       clr_ff = 1'b1;
    logic [1:0] cnt_in = 2'd3;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       door = 1'b0;
    logic       cnt_clr;
    logic [1:0] state;
    logic       siren;
    logic       entry_led;
    logic [1:0] disp;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    obs_t        exp_q[$];

    always #5 clk = ~clk;

    smart_alarm_ctrl #(
        .ENTRY_PERIODS(2),
        .SIREN_HALF   (4)
    ) dut (
        .CLK_IN   (clk),
        .CLR_FF   (clr_ff),
        .CNT_IN   (cnt_in),
        .ARM      (arm),
        .DISARM   (disarm),
        .DOOR     (door),
        .CNT_CLR  (cnt_clr),
        .STATE    (state),
        .SIREN    (siren),
        .ENTRY_LED(entry_led),
        .DISP     (disp)
    );

    function automatic obs_t mk(input logic [1:0] st, input logic sir, input logic [1:0] dsp);
        obs_t o;
        o.st    = st;
        o.clr   = (st != 2'd2);
        o.led   = (st == 2'd2);
        o.siren = sir;
        o.disp  = dsp;
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.st    = state;
        o.clr   = cnt_clr;
        o.siren = siren;
        o.led   = entry_led;
        o.disp  = disp;
        return o;
    endfunction

    // Monitor: one expectation per clock edge, checked just after the edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual();
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL vec%0d: got st=%0d clr=%0b sir=%0b led=%0b disp=%0d, want st=%0d clr=%0b sir=%0b led=%0b disp=%0d",
                             n_vec, a.st, a.clr, a.siren, a.led, a.disp,
                             e.st, e.clr, e.siren, e.led, e.disp);
                end
            end
        end
    end

    task automatic step(input logic a, input logic d, input logic dr, input logic [1:0] c,
                        input logic [1:0] est, input logic esir, input logic [1:0] edsp);
        @(negedge clk);
        arm    = a;
        disarm = d;
        door   = dr;
        cnt_in = c;
        exp_q.push_back(mk(est, esir, edsp));
    endtask

    initial begin
        obs_t ra;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t ra;
        int unsigned drain;
        repeat (2) @(negedge clk);
        clr_ff = 1'b0;

        // arm / disarm / simultaneous request
        step(0, 0, 0, 3, 2'd0, 0, 0);
        step(1, 0, 0, 3, 2'd1, 0, 0);
        step(0, 0, 0, 3, 2'd1, 0, 0);
        step(0, 1, 0, 3, 2'd0, 0, 0);
        step(1, 1, 0, 3, 2'd0, 0, 0);
        step(0, 0, 0, 3, 2'd0, 0, 0);

        // entry delay expiring after two wraps; door closes part-way
        step(1, 0, 0, 3, 2'd1, 0, 0);
        step(0, 0, 1, 3, 2'd2, 0, 3);
        step(0, 0, 1, 3, 2'd2, 0, 3);
        step(0, 0, 1, 2, 2'd2, 0, 2);
        step(0, 0, 1, 1, 2'd2, 0, 1);
        step(0, 0, 1, 0, 2'd2, 0, 0);
        step(0, 0, 0, 3, 2'd2, 0, 3);
        step(0, 0, 0, 2, 2'd2, 0, 2);
        step(0, 0, 0, 1, 2'd2, 0, 1);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 0, 3, 2'd3, 1, 0);

        // siren 1111 0000 1111 0000, ARM ignored in ALARM
        for (int i = 1; i < 16; i++)
            step(i[0], 0, 0, 3, 2'd3, ((i / 4) % 2) == 0, 0);
        step(0, 1, 0, 3, 2'd0, 0, 0);

        // disarm beats expiry on the second wrap
        step(1, 0, 0, 3, 2'd1, 0, 0);
        step(0, 0, 1, 3, 2'd2, 0, 3);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 0, 3, 2'd2, 0, 3);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 1, 0, 3, 2'd0, 0, 0);
        step(0, 0, 0, 3, 2'd0, 0, 0);

        // leave ENTRY holding 0, re-enter at 3: only genuine wraps count
        step(1, 0, 0, 3, 2'd1, 0, 0);
        step(0, 0, 1, 3, 2'd2, 0, 3);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 1, 0, 0, 2'd0, 0, 0);
        step(1, 0, 0, 0, 2'd1, 0, 0);
        step(0, 0, 0, 0, 2'd1, 0, 0);
        step(0, 0, 1, 3, 2'd2, 0, 3);
        step(0, 0, 0, 3, 2'd2, 0, 3);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 0, 3, 2'd2, 0, 3);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 0, 3, 2'd3, 1, 0);
        step(0, 0, 0, 3, 2'd3, 1, 0);
        step(0, 0, 0, 3, 2'd3, 1, 0);

        // asynchronous reset mid-cycle in ALARM with the siren high
        @(negedge clk);
        arm = 1'b1;
        #2 clr_ff = 1'b1;
        #1;
        ra = actual();
        n_vec++;
        if (ra !== mk(2'd0, 0, 0)) begin
            n_err++;
            $display("FAIL async_reset: got st=%0d clr=%0b sir=%0b led=%0b disp=%0d, want st=0 clr=1 sir=0 led=0 disp=0",
                     ra.st, ra.clr, ra.siren, ra.led, ra.disp);
        end
        step(1, 0, 0, 3, 2'd0, 0, 0);
        step(1, 0, 0, 3, 2'd0, 0, 0);
        @(negedge clk);
        clr_ff = 1'b0;
        exp_q.push_back(mk(2'd1, 0, 0));
        step(0, 1, 0, 3, 2'd0, 0, 0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/smart_alarm_ctrl.md
Name: smart_alarm_ctrl

Overview:
- Intrusion-alarm controller for the smart-home design. Sits directly downstream of the 2-bit down counter, which counts 3,2,1,0,3,...
- Consumes the counter's {D1,D0} value as an entry-delay timebase and drives the counter's clear.
- Sequences disarmed, armed, entry-delay and alarm states, and drives the siren, entry LED and a remaining-count display.

Parameters:
- ENTRY_PERIODS, 2, number of full counter wraps (0 to 3) allowed in ENTRY before alarm; legal range 1..15.
- SIREN_HALF, 4, clock cycles per siren half-period (siren toggles every SIREN_HALF cycles); legal range 1..255.

Ports:
- CLK_IN  in  1  system clock; all state updates on the rising edge.
- CLR_FF  in  1  reset, asynchronous, active-high.
- CNT_IN  in  2  {D1,D0} from the down counter.
- ARM  in  1  arm request, level, synchronous.
- DISARM  in  1  disarm request, level, synchronous.
- DOOR  in  1  door-open sensor, level, synchronous.
- CNT_CLR  out  1  clear to the down counter; while high the counter is held at 3.
- STATE  out  2  current state encoding.
- SIREN  out  1  siren drive.
- ENTRY_LED  out  1  high in ENTRY.
- DISP  out  2  remaining count for the display.

Behaviour:
- Clock and reset: one clock, CLK_IN. CLR_FF is asynchronous active-high. While CLR_FF is high:
  - STATE=0 (DISARMED), CNT_CLR=1, SIREN=0, ENTRY_LED=0, DISP=0.
  - Period counter=0, siren timer=0, previous-count register=3.
- Outputs: all registered. State changes are visible one cycle after the qualifying input is sampled.
- States: DISARMED=0, ARMED=1, ENTRY=2, ALARM=3.
- DISARMED:
  - ARM=1 and DISARM=0 -> ARMED.
  - ARM and DISARM together -> stay (DISARM priority).
- ARMED:
  - DISARM=1 -> DISARMED.
  - Otherwise DOOR=1 -> ENTRY; on entry the period counter is cleared to 0.
- ENTRY:
  - CNT_CLR=0, releasing the counter.
  - Wrap event: previous CNT_IN==0 and current CNT_IN==3. Each wrap event increments the period counter.
  - DISARM=1 -> DISARMED. DISARM beats an expiry in the same cycle.
  - Otherwise, when a wrap event occurs with period counter == ENTRY_PERIODS-1 -> ALARM.
  - DOOR is ignored in ENTRY; closing the door does not cancel the delay.
- ALARM:
  - SIREN starts at 1 on entry and toggles every SIREN_HALF cycles; the siren timer wraps at SIREN_HALF-1.
  - DISARM=1 -> DISARMED with SIREN=0 next cycle.
  - ARM is ignored.
- CNT_CLR: 1 in DISARMED, ARMED and ALARM; 0 only in ENTRY.
- Previous-count register:
  - Loads CNT_IN every cycle in ENTRY.
  - Forced to 3 in all other states, so a stale 0 never fakes a wrap on ENTRY entry.
- ENTRY_LED = (STATE==ENTRY).
- DISP: registered CNT_IN while in ENTRY, else 0.
- Width rules: period counter is 4 bits and siren timer is 8 bits, both unsigned. Neither overflows given the legal parameter ranges.
- Mid-operation reset: asynchronous return to the reset values from any state, including ALARM with the siren high.

Decomposition:
- Shared package (smart_home_pkg):
  - State encoding constants: ST_DISARMED, ST_ARMED, ST_ENTRY, ST_ALARM.
  - Counter terminal constants: CNT_TOP=3, CNT_BOT=0.
- One natural sub-module: alarm_siren_gen.
  - Siren timer and toggle logic, enabled by (STATE==ALARM).
  - Synchronous clear when not enabled; asynchronous CLR_FF.

Test Plan:
- Reset: assert CLR_FF mid-cycle with ARM=1 -> STATE=0, CNT_CLR=1, SIREN=0 immediately (asynchronous). STATE stays 0 while CLR_FF is high.
- Arm then disarm: ARM=1 for 1 cycle -> STATE=1 next cycle. DISARM=1 -> STATE=0. ARM and DISARM together in DISARMED -> STATE stays 0.
- Entry expiry (ENTRY_PERIODS=2):
  - Stimulus: ARMED, DOOR=1, CNT_IN driven 3,2,1,0,3,2,1,0,3.
  - Required: STATE=2 and CNT_CLR=0. DISP tracks CNT_IN one cycle late.
  - Required: STATE=3 one cycle after the second 0->3 wrap. SIREN=1 with ENTRY_LED=0.
- Entry disarm race: in ENTRY with period counter=1, drive CNT_IN 0->3 and DISARM=1 in the same cycle -> STATE=0, never 3; SIREN stays 0.
- Siren waveform (SIREN_HALF=4): in ALARM for 16 cycles -> SIREN pattern 1111 0000 1111 0000. DISARM -> SIREN=0 and STATE=0 next cycle.
- No false wrap: leave ENTRY with CNT_IN=0, re-arm, DOOR=1 while CNT_IN=3 -> period counter stays 0; no spurious increment.
